// File: rtl/rvga_stage_queue_pkg.sv
// rtl/rvga_stage_queue_pkg.sv - rvga shared types: stage queue depth default and count width helper
package rvga_types;

  localparam int rvga_stage_depth_default = 2;

  // Occupancy spans 0..DEPTH inclusive, so it needs one more code than the pointer.
  function automatic int rvga_stage_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rvga_stage_queue_ptr.sv
// rtl/rvga_stage_queue_ptr.sv - wrapping queue pointer with increment enable and synchronous clear
module rvga_stage_queue_ptr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rvga_stage_queue.sv
// rtl/rvga_stage_queue.sv - elastic valid/ready buffer between two rvga pipeline stages
module rvga_stage_queue
  import rvga_types::*;
#(
  parameter int  WIDTH  = 32,
  parameter int  DEPTH  = rvga_stage_depth_default,
  parameter bit  BYPASS = 1'b0,
  localparam int CW     = rvga_stage_cnt_w(DEPTH),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             v_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             empty;
  logic             full;
  logic             pass;
  logic             enq;
  logic             deq;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign ready_o = !full;

  // A pass-through word is consumed straight from data_i and never touches storage.
  assign pass = BYPASS && empty && v_i && ready_i;
  assign enq  = v_i && !full && !flush_i && !pass;
  assign deq  = !empty && ready_i;

  always_comb begin
    v_o    = !empty;
    data_o = mem_q[rptr];
    if (BYPASS) begin
      v_o = !empty || v_i;
      if (empty) begin
        data_o = data_i;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      count_d = '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (enq) begin
      mem_d[wptr] = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  rvga_stage_queue_ptr #(.W(PW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .inc_i (deq),
    .ptr_o (rptr)
  );

  rvga_stage_queue_ptr #(.W(PW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .inc_i (enq),
    .ptr_o (wptr)
  );

  assign count_o = count_q;

endmodule

// File: tb/tb_rvga_stage_queue.sv
// tb/tb_rvga_stage_queue.sv - scoreboard bench for rvga_stage_queue, plain and bypass instances
module tb_rvga_stage_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        v_i;
  logic [31:0] data_i;
  logic        ready_i;

  logic        ready_o0, v_o0, ready_o1, v_o1;
  logic [31:0] data_o0, data_o1;
  logic [2:0]  count_o0, count_o1;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  rvga_stage_queue #(.WIDTH(32), .DEPTH(4), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o0), .v_o(v_o0), .data_o(data_o0), .ready_i(ready_i), .count_o(count_o0)
  );

  rvga_stage_queue #(.WIDTH(32), .DEPTH(4), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o1), .v_o(v_o1), .data_o(data_o1), .ready_i(ready_i), .count_o(count_o1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every consumer handshake pops the model head and compares payload.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && v_o0 && ready_i) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_output: got %h expected none", data_o0);
      end else begin
        check("dut0_data", data_o0, q0.pop_front());
      end
    end
    if (rst_n === 1'b1 && v_o1 && ready_i) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_output: got %h expected none", data_o1);
      end else begin
        check("dut1_data", data_o1, q1.pop_front());
      end
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    check("dut0_count", {29'd0, count_o0}, q0.size());
    check("dut1_count", {29'd0, count_o1}, q1.size());
    check("dut0_ready", {31'd0, ready_o0}, {31'd0, q0.size() < 4});
    check("dut0_valid", {31'd0, v_o0}, {31'd0, q0.size() != 0});
    v_i = v; data_i = d; ready_i = r; flush_i = f;
    #1;
    if (f) begin
      q0.delete();
      q1.delete();
    end else begin
      if (v && ready_o0) q0.push_back(d);
      if (v && ready_o1) q1.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic        rv, rr, rf;
    logic [31:0] rd;
    rst_n = 1'b0; flush_i = 1'b0; v_i = 1'b0; data_i = '0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_v_o", {31'd0, v_o0}, 32'd0);
    check("reset_ready_o", {31'd0, ready_o0}, 32'd1);
    check("reset_count", {29'd0, count_o0}, 32'd0);
    check("reset_data_o", data_o0, 32'd0);
    check("reset_count_byp", {29'd0, count_o1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check("single_v_o", {31'd0, v_o0}, 32'd1);
    check("single_data", data_o0, 32'hDEADBEEF);
    check("single_count", {29'd0, count_o0}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
    check("full_ready_o", {31'd0, ready_o0}, 32'd0);
    check("full_count", {29'd0, count_o0}, 32'd4);
    step(1'b1, 32'h99, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("full_recover_ready", {31'd0, ready_o0}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'd10, 1'b0, 1'b0);
    step(1'b1, 32'd11, 1'b0, 1'b0);
    step(1'b1, 32'd12, 1'b1, 1'b0);
    check("simul_count", {29'd0, count_o0}, 32'd2);
    step(1'b1, 32'd13, 1'b1, 1'b0);
    check("simul_count2", {29'd0, count_o0}, 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rv = 1'($urandom_range(0, 1));
      rd = $urandom;
      rf = ($urandom_range(0, 15) == 0);
      rr = rf ? 1'b0 : 1'($urandom_range(0, 1));
      step(rv, rd, rr, rf);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step(1'b1, 32'h70 + i, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b0, 1'b1);
    check("flush_count", {29'd0, count_o0}, 32'd0);
    check("flush_v_o", {31'd0, v_o0}, 32'd0);
    check("flush_ready_o", {31'd0, ready_o0}, 32'd1);
    check("flush_count_byp", {29'd0, count_o1}, 32'd0);

    v_i = 1'b1; data_i = 32'hA5; ready_i = 1'b1; flush_i = 1'b0;
    #1;
    check("bypass_v_o", {31'd0, v_o1}, 32'd1);
    check("bypass_data", data_o1, 32'hA5);
    if (ready_o0) q0.push_back(32'hA5);
    if (ready_o1) q1.push_back(32'hA5);
    @(posedge clk); #1;
    check("bypass_count", {29'd0, count_o1}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'hA5, 1'b0, 1'b0);
    check("bypass_stall_count", {29'd0, count_o1}, 32'd1);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    v_i = 1'b0; ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_count", {29'd0, count_o0}, 32'd0);
    check("midreset_v_o", {31'd0, v_o0}, 32'd0);
    check("midreset_count_byp", {29'd0, count_o1}, 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("final_empty", {29'd0, count_o0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
